router_pkt_tx: RTL and testbench

Source-side packet transmitter for the 1x3 router. It collects a destination address and a payload from a host, then serialises one router packet onto the router input port: a header byte, the payload bytes, then an XOR parity byte. It honours the router's `busy` back-pressure. The full payload is buffered before transmission starts, so `packet_valid` is never asserted with stale data.

---
 rtl/router_pkt_tx_pkg.sv | 37 +++
 rtl/router_pkt_tx_if.sv | 30 +++
 rtl/router_tx_buf.sv | 53 +++++
 rtl/router_pkt_tx.sv | 149 ++++++++++++++
 tb/tb_router_pkt_tx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the 1x3 router packet transmitter.
//   - tx_state_e   : transmitter FSM states
//   - DEST_INVALID : reserved destination code, rejected on request
//   - header layout: length in [7:2], destination in [1:0]
//   - MAX_LEN      : largest payload the 6-bit length field can describe
//   - make_header  : packs {len, dest} into a header byte
package router_pkg;

    localparam int unsigned MAX_LEN  = 63;

    localparam int unsigned LEN_W    = 6;
    localparam int unsigned DEST_W   = 2;
    localparam int unsigned LEN_MSB  = 7;
    localparam int unsigned LEN_LSB  = 2;
    localparam int unsigned DEST_MSB = 1;
    localparam int unsigned DEST_LSB = 0;

    localparam logic [DEST_W-1:0] DEST_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY
    } tx_state_e;

    function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                               input logic [DEST_W-1:0] dest);
        logic [7:0] h;
        h                    = '0;
        h[LEN_MSB:LEN_LSB]   = len;
        h[DEST_MSB:DEST_LSB] = dest;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host/router-side signal bundle of the packet transmitter.
//   master : host and router model (drives requests, payload and busy)
//   slave  : router_pkt_tx (drives ready, pl_ready, packet_valid, pkt_data,
//            done, err)
interface router_pkt_tx_if;

    logic                            start;
    logic [router_pkg::DEST_W-1:0]   dest;
    logic [router_pkg::LEN_W-1:0]    len;
    logic                            ready;
    logic                            pl_valid;
    logic [7:0]                      pl_data;
    logic                            pl_ready;
    logic                            busy;
    logic                            packet_valid;
    logic [7:0]                      pkt_data;
    logic                            done;
    logic                            err;

    modport master (
        output start, dest, len, pl_valid, pl_data, busy,
        input  ready, pl_ready, packet_valid, pkt_data, done, err
    );

    modport slave (
        input  start, dest, len, pl_valid, pl_data, busy,
        output ready, pl_ready, packet_valid, pkt_data, done, err
    );

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer for router_pkt_tx: DEPTH x WIDTH memory written at wr_ptr and
// read asynchronously at rd_ptr. Both pointers are cleared by clr at the start
// of every packet, so they never wrap within one packet.
//   clk, resetn : clock, synchronous active-low reset (pointers only)
//   clr         : clear both pointers
//   wr_en/wr_data : write one byte, advance wr_ptr
//   rd_en       : advance rd_ptr
//   rd_data     : byte at rd_ptr
//   wr_cnt      : bytes written since clr
//   rd_idx      : current read pointer
module router_tx_buf
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LEN_W-1:0] wr_cnt,
    output logic [LEN_W-1:0] rd_idx
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LEN_W-1:0] wr_ptr;
    logic [LEN_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign wr_cnt  = wr_ptr;
    assign rd_idx  = rd_ptr;

endmodule

// File: rtl/router_pkt_tx.sv
// Source-side packet transmitter for the 1x3 router. Accepts {dest, len},
// buffers the whole payload, then sends header, payload and XOR parity onto
// the router input, stalling while busy is high.
//   clk, resetn : clock, synchronous active-low reset
//   inj_err     : (only with ROUTER_TX_PARITY_ERR_INJ_EN) corrupt parity bit 0
//                 of the packet whose start is accepted while it is high
//   bus         : router_pkt_tx_if.slave (request, payload, router side)
// Optional feature macro: ROUTER_TX_PARITY_ERR_INJ_EN
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = router_pkg::MAX_LEN
) (
    input  logic clk,
    input  logic resetn,
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    input  logic inj_err,
`endif
    router_pkt_tx_if.slave bus
);

    tx_state_e        state, state_n;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       header_q;
    logic [7:0]       parity_q;
    logic             done_q, done_n;
    logic             err_q, err_n;

    logic             accept;
    logic             buf_clr;
    logic             wr_en;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_idx;
    logic [LEN_W-1:0] last_idx;
    logic [7:0]       hdr;
    logic [7:0]       par_init;

    assign hdr      = make_header(bus.len, bus.dest);
    assign last_idx = len_q - 1'b1;

    // Injection is folded into the accumulator seed, so the flag need not be
    // carried to the parity stage.
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    assign par_init = hdr ^ {7'b0, inj_err};
`else
    assign par_init = hdr;
`endif

    router_tx_buf #(
        .DEPTH (MAX_LEN + 1),
        .WIDTH (8)
    ) u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (buf_clr),
        .wr_en   (wr_en),
        .wr_data (bus.pl_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_cnt  (wr_cnt),
        .rd_idx  (rd_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            len_q    <= '0;
            header_q <= '0;
            parity_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done_n;
            err_q  <= err_n;
            if (accept) begin
                len_q    <= bus.len;
                header_q <= hdr;
                parity_q <= par_init;
            end else if (wr_en) begin
                parity_q <= parity_q ^ bus.pl_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_n   = 1'b0;
        accept  = 1'b0;
        buf_clr = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.dest == DEST_INVALID || bus.len == '0) begin
                        err_n = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        buf_clr = 1'b1;
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.pl_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt == last_idx) state_n = HEADER;
                end
            end
            HEADER: begin
                if (!bus.busy) state_n = PAYLOAD;
            end
            PAYLOAD: begin
                if (!bus.busy) begin
                    rd_en = 1'b1;
                    if (rd_idx == last_idx) state_n = PARITY;
                end
            end
            PARITY: begin
                if (!bus.busy) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready        = (state == IDLE);
    assign bus.pl_ready     = (state == LOAD);
    assign bus.packet_valid = (state == HEADER) || (state == PAYLOAD);
    assign bus.done         = done_q;
    assign bus.err          = err_q;

    always_comb begin
        bus.pkt_data = '0;
        unique case (state)
            HEADER:  bus.pkt_data = header_q;
            PAYLOAD: bus.pkt_data = rd_data;
            PARITY:  bus.pkt_data = parity_q;
            default: bus.pkt_data = '0;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
module tb_router_pkt_tx;

    logic        clk;
    logic        resetn;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    logic        inj_err;
`endif
    int unsigned total;
    int unsigned bad;
    logic [7:0]  pl [64];
    logic [7:0]  par;

    router_pkt_tx_if bus();

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clk     (clk),
        .resetn  (resetn),
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        .inj_err (inj_err),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] d, input logic [5:0] l);
        bus.start = 1'b1;
        bus.dest  = d;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic load(input int unsigned n, input bit gaps);
        for (int unsigned i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                bus.pl_valid = 1'b0;
                @(negedge clk);
                check("load_gap_pv", bus.packet_valid, 0);
            end
            bus.pl_valid = 1'b1;
            bus.pl_data  = pl[i];
            @(negedge clk);
            if (i + 1 < n) check("load_pv", bus.packet_valid, 0);
        end
        bus.pl_valid = 1'b0;
    endtask

    // Observe from the header cycle to the first IDLE cycle; busy is raised for
    // exactly the cycle index busy_at (negative: never).
    task automatic run_tx(input logic [7:0] hdr, input int unsigned n,
                          input logic [7:0] exp_par, input int busy_at);
        int unsigned k;
        int unsigned cyc;
        logic [7:0]  exp_d;
        logic        b;
        k   = 0;
        cyc = 0;
        while (k < n + 2 && cyc < 400) begin
            if (k == 0)      exp_d = hdr;
            else if (k <= n) exp_d = pl[k-1];
            else             exp_d = exp_par;
            check("tx_pv", bus.packet_valid, (k <= n) ? 1 : 0);
            check("tx_data", bus.pkt_data, exp_d);
            check("tx_done_low", bus.done, 0);
            b = (int'(cyc) == busy_at);
            bus.busy = b;
            @(negedge clk);
            if (!b) k++;
            cyc++;
        end
        bus.busy = 1'b0;
        check("tx_cycles", cyc, n + 2 + ((busy_at >= 0) ? 1 : 0));
        check("done_pulse", bus.done, 1);
        check("done_ready", bus.ready, 1);
        @(negedge clk);
        check("done_clear", bus.done, 0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        resetn       = 1'b0;
        bus.start    = 1'b0;
        bus.dest     = '0;
        bus.len      = '0;
        bus.pl_valid = 1'b0;
        bus.pl_data  = '0;
        bus.busy     = 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        inj_err      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_pl_ready", bus.pl_ready, 0);
        check("rst_pv", bus.packet_valid, 0);
        check("rst_data", bus.pkt_data, 8'h00);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        resetn = 1'b1;
        @(negedge clk);

        // pl_valid in IDLE is not accepted
        bus.pl_valid = 1'b1;
        @(negedge clk);
        check("idle_pl_ready", bus.pl_ready, 0);
        bus.pl_valid = 1'b0;

        // Basic packet: dest 0, len 3, FF 00 FF -> header 0C, parity 0C
        pl[0] = 8'hFF; pl[1] = 8'h00; pl[2] = 8'hFF;
        do_start(2'd0, 6'd3);
        check("t1_ready", bus.ready, 0);
        check("t1_pl_ready", bus.pl_ready, 1);
        load(3, 1'b0);
        run_tx(8'h0C, 3, 8'h0C, -1);

        // Same packet, busy for the cycle after the header
        do_start(2'd0, 6'd3);
        load(3, 1'b0);
        run_tx(8'h0C, 3, 8'h0C, 1);

        // Illegal requests
        do_start(2'd3, 6'd3);
        check("bad_dest_err", bus.err, 1);
        check("bad_dest_ready", bus.ready, 1);
        check("bad_dest_pv", bus.packet_valid, 0);
        @(negedge clk);
        check("bad_dest_err_clr", bus.err, 0);
        check("bad_dest_ready2", bus.ready, 1);
        do_start(2'd1, 6'd0);
        check("bad_len_err", bus.err, 1);
        check("bad_len_ready", bus.ready, 1);
        check("bad_len_pv", bus.packet_valid, 0);
        @(negedge clk);
        check("bad_len_err_clr", bus.err, 0);
        check("bad_len_pv2", bus.packet_valid, 0);

        // Max length, dest 2, gapped payload -> header FE
        par = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            pl[i] = 8'($urandom);
            par   = par ^ pl[i];
        end
        do_start(2'd2, 6'd63);
        check("t4_pl_ready", bus.pl_ready, 1);
        do_start(2'd3, 6'd5);  // ignored while loading
        check("load_start_no_err", bus.err, 0);
        check("load_start_pl_ready", bus.pl_ready, 1);
        load(63, 1'b1);
        run_tx(8'hFE, 63, par, 5);

        // Reset during PAYLOAD, then a fresh packet
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        do_start(2'd1, 6'd4);
        load(4, 1'b0);
        check("rr_header", bus.pkt_data, 8'h11);
        @(negedge clk);
        @(negedge clk);
        check("rr_mid_pv", bus.packet_valid, 1);
        check("rr_mid_data", bus.pkt_data, 8'h22);
        resetn = 1'b0;
        @(negedge clk);
        check("rr_pv", bus.packet_valid, 0);
        check("rr_ready", bus.ready, 1);
        check("rr_pl_ready", bus.pl_ready, 0);
        check("rr_data", bus.pkt_data, 8'h00);
        check("rr_done", bus.done, 0);
        resetn = 1'b1;
        @(negedge clk);
        pl[0] = 8'hA5; pl[1] = 8'h3C;
        do_start(2'd1, 6'd2);
        load(2, 1'b0);
        run_tx(8'h09, 2, 8'h90, -1);

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        // Injected parity error: flag sampled only at start acceptance
        pl[0] = 8'hFF; pl[1] = 8'h00; pl[2] = 8'hFF;
        inj_err = 1'b1;
        do_start(2'd0, 6'd3);
        inj_err = 1'b0;
        load(3, 1'b0);
        run_tx(8'h0C, 3, 8'h0D, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
